// File: rtl/vga_pkg.sv
// Shared VGA pipeline types: pixel stream bundle, frame-grab states and window defaults.
package vga_pkg;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic [11:0] rgb;
   } vga_if_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      ARMED,
      CAPTURE,
      FLUSH
   } grab_state_t;

   localparam int unsigned GRAB_WIN_X      = 64;
   localparam int unsigned GRAB_WIN_Y      = 64;
   localparam int unsigned GRAB_WIN_W      = 256;
   localparam int unsigned GRAB_WIN_H      = 192;
   localparam int unsigned GRAB_THRESH     = 24;
   localparam int unsigned GRAB_FIFO_DEPTH = 32;

   // Dark pixels count as ink.
   function automatic logic ink_bit(input logic [11:0] rgb, input int unsigned thresh);
      logic [5:0] sum;
      sum = {2'b00, rgb[11:8]} + {2'b00, rgb[7:4]} + {2'b00, rgb[3:0]};
      return (32'(sum) < thresh);
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a registered output stage; count includes the byte held at the output.
module byte_fifo #(
   parameter int unsigned DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [7:0]                 rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] mcnt_q;
   logic          out_valid_q;
   logic [7:0]    out_data_q;

   logic pop, load, wr_ok, from_mem, bypass, mem_wr;

   assign count    = mcnt_q + CW'(out_valid_q);
   assign pop      = out_valid_q && rd_ready;
   assign load     = !out_valid_q || pop;
   assign wr_ok    = wr_en && (count != CW'(DEPTH));
   assign from_mem = load && (mcnt_q != '0);
   // An empty FIFO forwards the write straight into the output register.
   assign bypass   = load && (mcnt_q == '0) && wr_ok;
   assign mem_wr   = wr_ok && !bypass;

   assign rd_valid = out_valid_q;
   assign rd_data  = out_data_q;

   always_ff @(posedge clk) begin
      if (!rst && !clear && mem_wr) begin
         mem_q[wptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         mcnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (mem_wr) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (from_mem) begin
            out_data_q <= mem_q[rptr_q];
            rptr_q     <= rptr_q + PW'(1);
         end else if (bypass) begin
            out_data_q <= wr_data;
         end
         out_valid_q <= from_mem || bypass || (out_valid_q && !pop);
         mcnt_q      <= mcnt_q + CW'(mem_wr) - CW'(from_mem);
      end
   end

endmodule

// File: rtl/vga_frame_grab.sv
// Captures one canvas window row per frame as 1-bit ink pixels, packed MSB-first into bytes.
module vga_frame_grab
   import vga_pkg::*;
#(
   parameter int unsigned WIN_X      = GRAB_WIN_X,
   parameter int unsigned WIN_Y      = GRAB_WIN_Y,
   parameter int unsigned WIN_W      = GRAB_WIN_W,
   parameter int unsigned WIN_H      = GRAB_WIN_H,
   parameter int unsigned THRESH     = GRAB_THRESH,
   parameter int unsigned FIFO_DEPTH = GRAB_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  vga_if_t    vga_in,
   input  logic       cap_start,
   input  logic       cap_abort,
   output logic       busy,
   output logic       done,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready
);

   localparam int unsigned BPR = WIN_W / 8;
   localparam int unsigned RW  = $clog2(WIN_H + 1);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

   grab_state_t   state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [2:0]    pix_q, pix_d;
   logic [7:0]    sr_q, sr_d;
   logic          push_q, push_d;
   logic          done_q, done_d;
   logic [CW-1:0] fifo_count;

   logic fs, row_line, at_first, at_last, ink, has_room, pop, drains, shift;

   assign fs       = (vga_in.vcount == '0) && (vga_in.hcount == '0);
   assign row_line = vga_in.vcount == 11'(WIN_Y + 32'(row_q));
   assign at_first = vga_in.hcount == 11'(WIN_X);
   assign at_last  = vga_in.hcount == 11'(WIN_X + WIN_W - 1);
   assign ink      = ink_bit(vga_in.rgb, THRESH);
   assign has_room = (FIFO_DEPTH - 32'(fifo_count)) >= BPR;
   assign pop      = byte_valid && byte_ready;
   // The FIFO will be empty after this edge and no packed byte is still on its way in.
   assign drains   = !push_q && ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      pix_d   = pix_q;
      sr_d    = sr_q;
      push_d  = 1'b0;
      done_d  = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cap_start) begin
               row_d   = '0;
               pix_d   = '0;
               sr_d    = '0;
               state_d = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            if (fs && has_room) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (row_line && at_first) begin
               shift   = 1'b1;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            shift = 1'b1;
            if (at_last) begin
               row_d   = row_q + RW'(1);
               state_d = (row_q + RW'(1) == RW'(WIN_H)) ? FLUSH : WAIT_FRAME;
            end
         end
         FLUSH: begin
            if (drains) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (shift) begin
         sr_d  = {sr_q[6:0], ink};
         pix_d = pix_q + 3'd1;
         if (pix_q == 3'd7) begin
            push_d = 1'b1;
         end
      end
      if (cap_abort) begin
         state_d = IDLE;
         row_d   = '0;
         pix_d   = '0;
         sr_d    = '0;
         push_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         pix_q   <= '0;
         sr_q    <= '0;
         push_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         pix_q   <= pix_d;
         sr_q    <= sr_d;
         push_q  <= push_d;
         done_q  <= done_d;
      end
   end

   byte_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (cap_abort),
      .wr_en    (push_q),
      .wr_data  (sr_q),
      .rd_ready (byte_ready),
      .rd_valid (byte_valid),
      .rd_data  (byte_data),
      .count    (fifo_count)
   );

   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_vga_frame_grab.sv
// Scoreboard bench for vga_frame_grab on a small synthetic raster.
module tb_vga_frame_grab;
   import vga_pkg::*;

   localparam int WX = 8, WY = 4, WW = 16, WH = 2, TH = 24, DEPTH = 2;
   localparam int BPR = WW / 8;
   localparam int HTOT = 40, VTOT = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   vga_if_t    vga_in;
   logic       cap_start = 1'b0, cap_abort = 1'b0, byte_ready = 1'b0;
   logic       busy, done, byte_valid;
   logic [7:0] byte_data;

   always #5 clk = ~clk;

   vga_frame_grab #(
      .WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH), .THRESH(TH), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vga_in     (vga_in),
      .cap_start  (cap_start),
      .cap_abort  (cap_abort),
      .busy       (busy),
      .done       (done),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready)
   );

   int total = 0, bad = 0;
   int h = HTOT - 1, v = VTOT - 1, fs_cnt = 0, pix_mode = 0;
   logic [11:0] fpix [WH][WW];
   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];
   bit m_busy = 0;
   int m_rows = 0, m_pushed = 0, hs = 0, done_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit ink(input logic [11:0] c);
      return (int'(c[11:8]) + int'(c[7:4]) + int'(c[3:0])) < TH;
   endfunction

   function automatic logic [11:0] pick();
      case ($urandom_range(4))
         0: return 12'h000;
         1: return 12'hFFF;
         2: return 12'h888;
         3: return 12'h887;
         default: return 12'($urandom);
      endcase
   endfunction

   task automatic gen_frame();
      for (int r = 0; r < WH; r++) begin
         for (int x = 0; x < WW; x++) begin
            case (pix_mode)
               1: fpix[r][x] = 12'h000;
               2: fpix[r][x] = (x % 2 == 0) ? 12'hFFF : 12'h000;
               3: fpix[r][x] = (x % 2 == 0) ? 12'h888 : 12'h887;
               default: fpix[r][x] = pick();
            endcase
         end
      end
   endtask

   // A frame carries the next row only if the buffer has room for it at frame start.
   task automatic model_fs();
      logic [7:0] b;
      if (m_busy && m_rows < WH && (DEPTH - (m_pushed - hs)) >= BPR) begin
         for (int k = 0; k < BPR; k++) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
               if (ink(fpix[m_rows][k * 8 + i])) b = b | (8'h80 >> i);
            end
            exp_q.push_back(b);
         end
         m_pushed += BPR;
         m_rows++;
      end
   endtask

   task automatic step(input bit start, input bit abort, input int pct);
      @(posedge clk);
      #1;
      if (h == HTOT - 1) begin
         h = 0;
         v = (v == VTOT - 1) ? 0 : v + 1;
      end else begin
         h = h + 1;
      end
      if (h == 0 && v == 0) begin
         fs_cnt++;
         gen_frame();
         model_fs();
      end
      vga_in.hcount = 11'(h);
      vga_in.vcount = 11'(v);
      if (v >= WY && v < WY + WH && h >= WX && h < WX + WW) vga_in.rgb = fpix[v - WY][h - WX];
      else vga_in.rgb = 12'($urandom);
      cap_start  = start;
      cap_abort  = abort;
      byte_ready = !abort && (int'($urandom_range(99)) < pct);
      if (abort) begin
         m_busy = 0;
         exp_q.delete();
      end else if (start && !m_busy) begin
         m_busy = 1; m_rows = 0; m_pushed = 0; hs = 0;
      end
   endtask

   task automatic run_capture(input int pct, input int hold, output int frames);
      int d0, f0, n;
      d0 = done_cnt;
      step(1, 0, (hold > 0) ? 0 : pct);
      @(negedge clk);
      check("busy_before_rise", busy, 0);
      f0 = fs_cnt;
      step(0, 0, (hold > 0) ? 0 : pct);
      @(negedge clk);
      check("busy_rise", busy, 1);
      n = 0;
      while (m_busy && n < 8 * HTOT * VTOT) begin
         step(0, 0, (fs_cnt - f0 < hold) ? 0 : pct);
         n++;
      end
      frames = fs_cnt - f0;
      if (m_busy) begin
         check("capture_timeout", 1, 0);
         step(0, 1, 0);
      end
      step(0, 0, pct);
      @(negedge clk);
      check("done_once", done_cnt, d0 + 1);
      check("busy_after", busy, 0);
   endtask

   // Monitor: pops the scoreboard on every handshake.
   initial begin
      bit prev_stall = 0, prev_clr = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (prev_stall && !prev_clr) check("hold_valid", byte_valid, 1);
            if (byte_valid && byte_ready) begin
               got_q.push_back(byte_data);
               if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
               else check("byte_data", byte_data, exp_q.pop_front());
               hs++;
            end
            if (done) begin
               check("done_cond", int'(m_busy && m_rows == WH && exp_q.size() == 0), 1);
               check("busy_with_done", busy, 0);
               m_busy = 0;
               done_cnt++;
            end
         end
         prev_stall = byte_valid && !byte_ready;
         prev_clr   = cap_abort || rst;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int fr, n, d0;
      vga_in = '0;
      repeat (3) step(0, 0, 0);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", byte_valid, 0);
      check("rst_data", byte_data, 0);
      rst = 1'b0;

      pix_mode = 1; got_q.delete();
      run_capture(100, 0, fr);
      check("black_frames", fr, 2);
      check("black_count", got_q.size(), 4);
      foreach (got_q[i]) check("black_byte", got_q[i], 8'hFF);

      pix_mode = 2; got_q.delete();
      run_capture(100, 0, fr);
      check("alt_count", got_q.size(), 4);
      foreach (got_q[i]) check("alt_byte", got_q[i], 8'h55);

      pix_mode = 3; got_q.delete();
      run_capture(100, 0, fr);
      check("thresh_count", got_q.size(), 4);
      foreach (got_q[i]) check("thresh_byte", got_q[i], 8'h55);

      pix_mode = 0;
      run_capture(100, 2, fr);
      check("backpressure_frames", fr, 3);

      for (int t = 0; t < 6; t++) begin
         case (t % 3)
            0: run_capture(100, 0, fr);
            1: run_capture(40, 0, fr);
            default: run_capture(1, 0, fr);
         endcase
      end

      // Abort in the middle of row 1.
      d0 = done_cnt;
      step(1, 0, 100);
      n = 0;
      while (!(m_rows == 2 && v == WY + 1 && h == WX + 5) && n < 4 * HTOT * VTOT) begin
         step(0, 0, 100);
         n++;
      end
      check("abort_reached", int'(m_rows == 2), 1);
      step(0, 1, 0);
      step(0, 0, 0);
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_valid", byte_valid, 0);
      check("abort_done", done, 0);
      repeat (20) step(0, 0, 100);
      check("abort_no_done", done_cnt, d0);
      run_capture(100, 0, fr);
      check("recapture_frames", fr, 2);

      // Start while busy must not restart the row count.
      d0 = done_cnt;
      step(1, 0, 100);
      n = 0;
      while (!(v == WY && h == WX + 2 && m_busy) && n < 4 * HTOT * VTOT) begin
         step(0, 0, 100);
         n++;
      end
      step(1, 0, 100);
      @(negedge clk);
      check("start_busy_ignored", busy, 1);
      n = 0;
      while (m_busy && n < 8 * HTOT * VTOT) begin
         step(0, 0, 100);
         n++;
      end
      step(0, 0, 100);
      check("start_busy_done", done_cnt, d0 + 1);
      check("start_busy_rows", m_rows, WH);

      // Reset in the middle of row 0.
      step(1, 0, 0);
      n = 0;
      while (!(v == WY && h == WX + 3 && m_busy) && n < 4 * HTOT * VTOT) begin
         step(0, 0, 0);
         n++;
      end
      rst = 1'b1;
      m_busy = 0;
      exp_q.delete();
      step(0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_valid", byte_valid, 0);
      check("midrst_data", byte_data, 0);
      run_capture(40, 0, fr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_frame_grab.md
# vga_frame_grab

Read-side counterpart of the VGA drawing pipeline. Taps a `vga_if` stream at the end of the draw chain and captures a rectangular canvas window as 1-bit ink/no-ink pixels. It captures one window row per frame, packs the pixels into bytes (MSB = leftmost pixel) and delivers them over a valid/ready byte stream to the printer/serial back end. Capture is flow-controlled per frame: a row is only captured when the output buffer can hold all of it, so no pixel is ever lost.

## Interface
- `WIN_X`, 64, window left column (hcount of first captured pixel)
- `WIN_Y`, 64, window top line (vcount of first captured row)
- `WIN_W`, 256, window width in pixels; multiple of 8; window fully inside visible area
- `WIN_H`, 192, window height in rows
- `THRESH`, 24, ink threshold on r+g+b (6-bit sum, 0..45)
- `FIFO_DEPTH`, 32, byte buffer depth; must be ≥ WIN_W/8, power of 2
- `clk`  in  1  pixel clock (40 MHz domain); one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous, active-high reset
- `vga_in`  in  vga_if  pixel stream; uses `hcount`, `vcount`, `rgb` only
- `cap_start`  in  1  single-cycle request to start a full-window capture
- `cap_abort`  in  1  single-cycle request to abandon the capture and discard buffered bytes
- `busy`  out  1  high from accepted `cap_start` until `done` or abort
- `done`  out  1  one-cycle pulse when the last byte has been accepted downstream
- `byte_data`  out  8  packed pixel byte
- `byte_valid`  out  1  `byte_data` valid
- `byte_ready`  in  1  downstream accepts byte when high with `byte_valid`

## Operation
- Ink bit = 1 when `rgb[11:8]+rgb[7:4]+rgb[3:0]` (zero-extended to 6 bits) < THRESH, else 0.
- Frame start (FS) = `vcount==0 && hcount==0`.
- IDLE: `busy`=0. On `cap_start` → row counter := 0, go to WAIT_FRAME.
- WAIT_FRAME: at FS, if FIFO free slots ≥ WIN_W/8 → ARMED; otherwise stay in WAIT_FRAME (frame skipped).
- ARMED: when `vcount==WIN_Y+row && hcount==WIN_X`, sample this pixel and go to CAPTURE.
- CAPTURE: sample every pixel for `hcount` in WIN_X..WIN_X+WIN_W-1 and shift it into the byte register, MSB first.
  - Every 8th pixel: push the byte into the FIFO. Free space is guaranteed by the WAIT_FRAME check.
  - After the last pixel: row++. If row==WIN_H → FLUSH, else → WAIT_FRAME.
- FLUSH: when the FIFO is empty and no byte is pending, pulse `done` and go to IDLE.
- `cap_start` while `busy` is ignored.
- `cap_abort` in any state:
  - go to IDLE next cycle, clear the FIFO and byte register, drop `byte_valid`, no `done`.
  - Abort takes priority over a simultaneous `cap_start`.
- Downstream handshake: a byte transfers on `byte_valid && byte_ready`. `byte_data` is held stable while `byte_valid && !byte_ready`. Bytes leave in capture order.
- Row counter width is `$clog2(WIN_H+1)`. Pixel counter is 3 bits and wraps 7→0 on each push.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `byte_valid`=0, `byte_data`=0, FIFO empty, counters 0.
- `busy` rises the cycle after `cap_start`.
- Latency: 8th pixel present on `vga_in` at cycle n → FIFO write at n+1 → `byte_valid` at n+2 when the FIFO was empty.
- The FS check uses the FIFO count registered at FS. A row captured in frame k is the row WIN_Y+row of that same frame.
- Minimum capture time is WIN_H frames. Each frame in which free space < WIN_W/8 at FS adds one frame.
- `done` asserts one cycle after the final handshake. `busy` falls in the same cycle `done` is high.
- `rst` mid-capture behaves identically to the reset values above on the next edge.

## Structure
- Add to shared `vga_pkg`:
  - `grab_state_t` enum (IDLE, WAIT_FRAME, ARMED, CAPTURE, FLUSH).
  - Default window constants.
- Sub-module `byte_fifo`: synchronous FIFO with parameter DEPTH, registered read port, `count` output and a synchronous `clear` input. Used for the byte buffer.

## Test plan
- WIN 16×2 at (8,4), all rgb=12'h000 → four bytes 0xFF in 2 frames, `done` pulse, `busy` low after.
- Pixels alternate 12'hFFF/12'h000 starting white at WIN_X → every byte 0x55.
- Threshold boundary: rgb=12'h888 (sum 24) → bit 0; rgb=12'h887 (sum 23) → bit 1.
- `byte_ready` held low through the second FS with FIFO_DEPTH=WIN_W/8 → row 1 is captured one frame later. The full byte sequence must be complete and in order.
- `cap_abort` mid-row 1 → IDLE next cycle, `byte_valid`=0, FIFO empty, no `done`. A following `cap_start` recaptures from row 0.
- `cap_start` while busy → ignored, no change to row count. `rst` mid-CAPTURE → all outputs at reset values next cycle.
